// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_pkg
// Description : Shared constants for the immediate-generator stage. Holds
//               the base opcode set (extended with LUI and AUIPC), the
//               funct3 codes that mark shift-immediate instructions and
//               the format codes reported alongside every immediate.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pipe_pkg;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // funct3 values of OP-IMM that carry a shift amount instead of imm12
    localparam logic [2:0] F3_SLL      = 3'b001;
    localparam logic [2:0] F3_SRL_SRA  = 3'b101;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ECALL = 3'd7
    } imm_fmt_e;

    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Handshake bundle for the immediate-generator stage.
//               Input side : in_valid, in_ready, in_inst, in_tag
//               Output side: out_valid, out_ready, out_imm, out_fmt,
//                            out_illegal, out_tag
//               master = the surrounding pipeline (offers instructions,
//               consumes results); slave = the stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [FMT_W-1:0] out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe_imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Purely combinational RV32I/RV64I immediate decoder.
//               Ports: i_inst    - raw 32-bit instruction
//                      o_imm     - immediate, sign-extended to XLEN
//                                  (shift amounts and ECALL zero-extended)
//                      o_fmt     - detected format code
//                      o_illegal - unknown opcode or reserved shamt bit
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ECALL_IMM = 10
) (
    input  wire logic [31:0]      i_inst,
    output logic      [XLEN-1:0]  o_imm,
    output logic      [FMT_W-1:0] o_fmt,
    output logic                  o_illegal
);

    localparam logic [XLEN-1:0] c_ecall_imm = XLEN'(ECALL_IMM);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm;
    imm_fmt_e        w_fmt;
    logic            w_illegal;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];

    // Size casts of signed operands sign-extend to XLEN.
    always_comb begin
        w_imm     = '0;
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP_IMM: begin
                if (is_shift_funct3(w_funct3)) begin
                    w_fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        w_imm = XLEN'(i_inst[25:20]);
                    end else begin
                        // shamt[5] is reserved on RV32
                        w_imm     = XLEN'(i_inst[24:20]);
                        w_illegal = i_inst[25];
                    end
                end else begin
                    w_fmt = FMT_I;
                    w_imm = XLEN'($signed(i_inst[31:20]));
                end
            end
            OPC_LOAD, OPC_JALR: begin
                w_fmt = FMT_I;
                w_imm = XLEN'($signed(i_inst[31:20]));
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                w_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B;
                w_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                       i_inst[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                w_fmt = FMT_U;
                w_imm = XLEN'($signed({i_inst[31:12], 12'd0}));
            end
            OPC_JAL: begin
                w_fmt = FMT_J;
                w_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                       i_inst[30:21], 1'b0}));
            end
            OPC_SYSTEM: begin
                w_fmt = FMT_ECALL;
                w_imm = c_ecall_imm;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign o_imm     = w_imm;
    assign o_fmt     = w_fmt;
    assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered, flow-controlled immediate generator between the
//               fetch/decode latch and the ID/EX register. Decoding happens
//               at accept time; this module only holds results and runs the
//               valid/ready handshake.
//               Ports: clk   - clock
//                      reset - asynchronous, active-high reset
//                      flush - synchronous kill of all held entries
//                      bus   - imm_gen_pipe_if.slave (in_* / out_* handshake)
//               SKID=1: main + skid register, in_ready = !skid_full (flop)
//               SKID=0: single register, in_ready = !out_valid || out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 32,
    parameter int ECALL_IMM = 10,
    parameter int SKID      = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      flush,
    imm_gen_pipe_if.slave  bus
);

    logic [XLEN-1:0]  w_dec_imm;
    logic [FMT_W-1:0] w_dec_fmt;
    logic             w_dec_illegal;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_drain;

    // Main (output) register
    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [FMT_W-1:0] r_main_fmt;
    logic             r_main_illegal;
    logic [TAG_W-1:0] r_main_tag;

    imm_decode #(
        .XLEN      (XLEN),
        .ECALL_IMM (ECALL_IMM)
    ) u_imm_decode (
        .i_inst    (bus.in_inst),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_drain  = r_main_valid && bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic             r_skid_valid;
            logic [XLEN-1:0]  r_skid_imm;
            logic [FMT_W-1:0] r_skid_fmt;
            logic             r_skid_illegal;
            logic [TAG_W-1:0] r_skid_tag;

            // Ready depends only on a flop, so the upstream timing path is
            // cut. Because ready is low whenever the skid slot is full, an
            // accept can only ever target an empty slot.
            assign w_in_ready = !r_skid_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_main_valid   <= 1'b0;
                    r_main_imm     <= '0;
                    r_main_fmt     <= FMT_NONE;
                    r_main_illegal <= 1'b0;
                    r_main_tag     <= '0;
                    r_skid_valid   <= 1'b0;
                    r_skid_imm     <= '0;
                    r_skid_fmt     <= FMT_NONE;
                    r_skid_illegal <= 1'b0;
                    r_skid_tag     <= '0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (!r_main_valid || w_drain) begin
                    // Main is free this edge: oldest entry (skid) first.
                    if (r_skid_valid) begin
                        r_main_valid   <= 1'b1;
                        r_main_imm     <= r_skid_imm;
                        r_main_fmt     <= r_skid_fmt;
                        r_main_illegal <= r_skid_illegal;
                        r_main_tag     <= r_skid_tag;
                        r_skid_valid   <= 1'b0;
                    end else if (w_accept) begin
                        r_main_valid   <= 1'b1;
                        r_main_imm     <= w_dec_imm;
                        r_main_fmt     <= w_dec_fmt;
                        r_main_illegal <= w_dec_illegal;
                        r_main_tag     <= bus.in_tag;
                    end else begin
                        r_main_valid   <= 1'b0;
                    end
                end else if (w_accept) begin
                    // Main is stalled: park the new entry in the skid slot.
                    r_skid_valid   <= 1'b1;
                    r_skid_imm     <= w_dec_imm;
                    r_skid_fmt     <= w_dec_fmt;
                    r_skid_illegal <= w_dec_illegal;
                    r_skid_tag     <= bus.in_tag;
                end
            end
        end else begin : g_no_skid
            // Drain and accept may coincide, keeping full throughput.
            assign w_in_ready = !r_main_valid || bus.out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_main_valid   <= 1'b0;
                    r_main_imm     <= '0;
                    r_main_fmt     <= FMT_NONE;
                    r_main_illegal <= 1'b0;
                    r_main_tag     <= '0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main_valid   <= 1'b1;
                    r_main_imm     <= w_dec_imm;
                    r_main_fmt     <= w_dec_fmt;
                    r_main_illegal <= w_dec_illegal;
                    r_main_tag     <= bus.in_tag;
                end else if (w_drain) begin
                    r_main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.out_imm     = r_main_imm;
    assign bus.out_fmt     = r_main_fmt;
    assign bus.out_illegal = r_main_illegal;
    assign bus.out_tag     = r_main_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Directed, self-checking bench for imm_gen_pipe. Three
//               instances: A (XLEN=32, SKID=1), B (XLEN=64, SKID=1, same
//               stimulus as A) and C (XLEN=32, SKID=0, own stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;

    // Shared stimulus for instances A and B
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    // Stimulus for instance C
    logic        nc_in_valid;
    logic [31:0] nc_in_inst;
    logic [31:0] nc_in_tag;
    logic        nc_out_ready;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) ifa ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) ifb ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) ifc ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_inst   = in_inst;
    assign ifa.in_tag    = in_tag;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_inst   = in_inst;
    assign ifb.in_tag    = in_tag;
    assign ifb.out_ready = out_ready;
    assign ifc.in_valid  = nc_in_valid;
    assign ifc.in_inst   = nc_in_inst;
    assign ifc.in_tag    = nc_in_tag;
    assign ifc.out_ready = nc_out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ECALL_IMM(10), .SKID(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifa));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ECALL_IMM(10), .SKID(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifb));
    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ECALL_IMM(10), .SKID(0)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifc));

    // Back-to-back stream: S, U, J, SHAMT
    logic [31:0] str_inst [4] = '{32'hFE112E23, 32'h123452B7, 32'hFFDFF06F, 32'h00309093};
    logic [31:0] str_imm  [4] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFC, 32'h00000003};
    logic [2:0]  str_fmt  [4] = '{3'd2, 3'd4, 3'd5, 3'd6};

    // Edge cases: illegal opcode, slli shamt[5], ECALL, lui 0x80000, beq -4
    logic [31:0] edg_inst  [5] = '{32'h0000007F, 32'h02109093, 32'h00000073, 32'h800002B7, 32'hFE000EE3};
    logic [31:0] edg_a_imm [5] = '{32'h0, 32'h1, 32'hA, 32'h80000000, 32'hFFFFFFFC};
    logic [2:0]  edg_fmt   [5] = '{3'd0, 3'd6, 3'd7, 3'd4, 3'd3};
    logic        edg_a_ill [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] edg_b_imm [5] = '{64'h0, 64'h21, 64'hA, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC};
    logic        edg_b_ill [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b1;
        nc_in_valid = 1'b0; nc_in_inst = '0; nc_in_tag = '0; nc_out_ready = 1'b1;
        repeat (2) tick();

        // ---------------- reset state ----------------
        check("rst_valid",   64'(ifa.out_valid),   64'd0);
        check("rst_imm",     64'(ifa.out_imm),     64'd0);
        check("rst_fmt",     64'(ifa.out_fmt),     64'd0);
        check("rst_illegal", 64'(ifa.out_illegal), 64'd0);
        check("rst_tag",     64'(ifa.out_tag),     64'd0);
        check("rst_c_valid", 64'(ifc.out_valid),   64'd0);
        reset = 1'b0;
        #1;
        check("rdy_after_rst",   64'(ifa.in_ready), 64'd1);
        check("rdy_after_rst_c", 64'(ifc.in_ready), 64'd1);

        // ---------------- single addi -1 ----------------
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h100;
        tick();
        in_valid = 1'b0;
        check("addi_valid", 64'(ifa.out_valid),   64'd1);
        check("addi_imm",   64'(ifa.out_imm),     64'hFFFFFFFF);
        check("addi_fmt",   64'(ifa.out_fmt),     64'd1);
        check("addi_tag",   64'(ifa.out_tag),     64'h100);
        check("addi_ill",   64'(ifa.out_illegal), 64'd0);
        check("addi_imm64", ifb.out_imm,          64'hFFFFFFFFFFFFFFFF);
        tick();
        check("addi_drained", 64'(ifa.out_valid), 64'd0);

        // ---------------- back-to-back stream ----------------
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = str_inst[i]; in_tag = 32'(i + 1);
            tick();
            check($sformatf("str%0d_valid", i), 64'(ifa.out_valid), 64'd1);
            check($sformatf("str%0d_imm", i),   64'(ifa.out_imm),   64'(str_imm[i]));
            check($sformatf("str%0d_fmt", i),   64'(ifa.out_fmt),   64'(str_fmt[i]));
            check($sformatf("str%0d_tag", i),   64'(ifa.out_tag),   64'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("str_end_valid", 64'(ifa.out_valid), 64'd0);

        // ---------------- edge-case encodings ----------------
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = edg_inst[i]; in_tag = 32'(i + 16);
            tick();
            check($sformatf("edg%0d_imm", i),   64'(ifa.out_imm),     64'(edg_a_imm[i]));
            check($sformatf("edg%0d_fmt", i),   64'(ifa.out_fmt),     64'(edg_fmt[i]));
            check($sformatf("edg%0d_ill", i),   64'(ifa.out_illegal), 64'(edg_a_ill[i]));
            check($sformatf("edg%0d_imm64", i), ifb.out_imm,          edg_b_imm[i]);
            check($sformatf("edg%0d_ill64", i), 64'(ifb.out_illegal), 64'(edg_b_ill[i]));
        end
        in_valid = 1'b0;
        tick();

        // ---------------- skid stall: tags 1,2,3 ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'd1;
        tick();
        check("stall_t1_tag", 64'(ifa.out_tag),  64'd1);
        check("stall_t1_rdy", 64'(ifa.in_ready), 64'd1);
        in_tag = 32'd2;
        tick();
        check("stall_t2_rdy", 64'(ifa.in_ready), 64'd0);
        check("stall_t2_tag", 64'(ifa.out_tag),  64'd1);
        in_tag = 32'd3;
        tick();
        check("stall_t3_rdy", 64'(ifa.in_ready), 64'd0);
        check("stall_t3_tag", 64'(ifa.out_tag),  64'd1);
        tick();
        check("stall_t4_val", 64'(ifa.out_valid), 64'd1);
        check("stall_t4_tag", 64'(ifa.out_tag),   64'd1);
        out_ready = 1'b1;
        tick();
        check("rel_tag2",  64'(ifa.out_tag),   64'd2);
        check("rel_val2",  64'(ifa.out_valid), 64'd1);
        check("rel_rdy",   64'(ifa.in_ready),  64'd1);
        tick();
        in_valid = 1'b0;
        check("rel_tag3",  64'(ifa.out_tag),   64'd3);
        check("rel_val3",  64'(ifa.out_valid), 64'd1);
        tick();
        check("rel_empty", 64'(ifa.out_valid), 64'd0);

        // ---------------- flush with two held entries ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 32'h11;
        tick();
        in_tag = 32'h12;
        tick();
        check("fl_pre_rdy", 64'(ifa.in_ready), 64'd0);
        flush = 1'b1; in_tag = 32'h13;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(ifa.out_valid), 64'd0);
        check("fl_rdy",   64'(ifa.in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        check("fl_gone1", 64'(ifa.out_valid), 64'd0);
        tick();
        check("fl_gone2", 64'(ifa.out_valid), 64'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFE112E23; in_tag = 32'h55;
        tick();
        in_valid = 1'b0;
        check("ar_pre_val", 64'(ifa.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", 64'(ifa.out_valid),   64'd0);
        check("ar_imm",   64'(ifa.out_imm),     64'd0);
        check("ar_fmt",   64'(ifa.out_fmt),     64'd0);
        check("ar_ill",   64'(ifa.out_illegal), 64'd0);
        check("ar_tag",   64'(ifa.out_tag),     64'd0);
        tick();
        reset = 1'b0; out_ready = 1'b1;
        #1;
        check("ar_rdy", 64'(ifa.in_ready), 64'd1);

        // ---------------- SKID=0 instance ----------------
        nc_out_ready = 1'b0;
        nc_in_valid = 1'b1; nc_in_inst = 32'hFFF00093; nc_in_tag = 32'h21;
        #1;
        check("ns_rdy_empty", 64'(ifc.in_ready), 64'd1);
        tick();
        check("ns_val1", 64'(ifc.out_valid), 64'd1);
        check("ns_tag1", 64'(ifc.out_tag),   64'h21);
        check("ns_imm1", 64'(ifc.out_imm),   64'hFFFFFFFF);
        check("ns_rdy_stall", 64'(ifc.in_ready), 64'd0);
        nc_in_inst = 32'h123452B7; nc_in_tag = 32'h22;
        tick();
        check("ns_hold_tag", 64'(ifc.out_tag), 64'h21);
        nc_out_ready = 1'b1;
        #1;
        check("ns_rdy_comb", 64'(ifc.in_ready), 64'd1);
        tick();
        nc_in_valid = 1'b0;
        check("ns_tag2", 64'(ifc.out_tag),   64'h22);
        check("ns_imm2", 64'(ifc.out_imm),   64'h12345000);
        check("ns_val2", 64'(ifc.out_valid), 64'd1);
        tick();
        check("ns_empty", 64'(ifc.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
